// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32I funct3 codes, watchdog default.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        else    ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        return ok;
    endfunction

    // funct3[1:0] encodes access size for every legal code.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store-data replication and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata_lane,
    output logic [WIDTH-1:0] rdata_ext
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {(WIDTH/8){wdata[7:0]}};
            end
            2'b01: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {(WIDTH/16){wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
        if (!we) be = 4'b0000;
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3)
            LB:      rdata_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            LH:      rdata_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            LBU:     rdata_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            LHU:     rdata_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, faults on misalignment/illegal funct3 (LSU_TIMEOUT_EN adds watchdog).
// Latency: fault responds the cycle after accept; memory access responds the cycle after mem_ack.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack; responses cannot be stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_fault,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef struct packed {
        logic             we;
        logic [2:0]       funct3;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } req_t;

    lsu_state_t       state_q, state_d;
    req_t             req_q;
    logic [WIDTH-1:0] rdata_q;
    logic             fault_q;
    logic             accept, req_bad, in_access, timeout_hit;
    logic [3:0]       be_w;
    logic [WIDTH-1:0] wdata_w, rdata_w;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_bad   = !f3_legal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
    assign in_access = (state_q == ACCESS);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        tmo_cnt <= '0;
        else if (accept)                tmo_cnt <= '0;
        else if (in_access && !mem_ack) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    // An ack on the last permitted cycle still wins over the timeout.
    assign timeout_hit = in_access && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_bad ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            req_q.we     <= req_we;
            req_q.funct3 <= req_funct3;
            req_q.addr   <= req_addr;
            req_q.wdata  <= req_wdata;
            rdata_q      <= '0;
            fault_q      <= req_bad;
        end else if (in_access) begin
            if (mem_ack)          rdata_q <= req_q.we ? '0 : rdata_w;
            else if (timeout_hit) fault_q <= 1'b1;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .we         (req_q.we),
        .funct3     (req_q.funct3),
        .addr_lo    (req_q.addr[1:0]),
        .wdata      (req_q.wdata),
        .rdata      (mem_rdata),
        .be         (be_w),
        .wdata_lane (wdata_w),
        .rdata_ext  (rdata_w)
    );

    // Command and response buses are forced to zero outside their owning state.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_fault = resp_valid && fault_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign mem_req    = in_access;
    assign mem_we     = in_access && req_q.we;
    assign mem_addr   = in_access ? {req_q.addr[WIDTH-1:2], 2'b00} : '0;
    assign mem_be     = in_access ? be_w : 4'b0000;
    assign mem_wdata  = in_access ? wdata_w : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-array memory reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] rdata; logic fault; int kind; int cyc; } exp_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } cmd_t;

    exp_t        sb[$];
    cmd_t        cmdq[$];
    int          ackq[$];
    int          vectors = 0, errors = 0, cyc = 0, resp_count = 0;
    int          next_wait = 0;
    bit          rand_wait = 1'b0;
    logic [7:0]  ref_bytes [0:255];
    logic [31:0] mem_words [0:63];
    logic [31:0] last_rdata = 32'd0;
    logic        last_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        int   ecyc;
        if (resp_valid) begin
            resp_count++;
            last_rdata = resp_rdata;
            last_fault = resp_fault;
            if (sb.size() == 0) fail("unexpected_resp");
            else begin
                e = sb.pop_front();
                ecyc = e.cyc;
                if (e.kind == 1) begin
                    if (ackq.size() == 0) begin fail("resp_without_ack"); ecyc = -1; end
                    else ecyc = ackq.pop_front() + 1;
                end
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
                check("resp_cycle", cyc, ecyc);
            end
        end
    end

    // Memory slave: word array, checks each command against the expected queue
    bit   in_acc = 1'b0;
    int   wait_left = 0;
    cmd_t cur;
    always @(negedge clk) begin
        int idx;
        if (mem_req && !rst) begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                wait_left = rand_wait ? int'($urandom_range(0, 4)) : next_wait;
                if (cmdq.size() == 0) begin
                    fail("mem_req_unexpected");
                    cur = '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata};
                end else begin
                    cur = cmdq.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                check("mem_addr_stable", mem_addr, cur.addr);
                check("mem_be_stable", {28'd0, mem_be}, {28'd0, cur.be});
            end
            if (wait_left == 0) begin
                idx = int'(mem_addr[7:2]);
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem_words[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = mem_words[idx];
                end
                mem_ack = 1'b1;
                ackq.push_back(cyc);
                in_acc = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            in_acc    = 1'b0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit tmo);
        int          guard = 0;
        int          sz, off;
        bit          legal, mis;
        exp_t        e;
        cmd_t        c;
        logic [31:0] v;
        @(negedge clk);
        while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
        if (!req_ready) begin fail("req_ready_timeout"); return; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;

        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz    = 1 << f3[1:0];
        mis   = legal && ((addr % sz) != 0);
        off   = int'(addr[7:0]);
        e.cyc = cyc + 1;
        if (!legal || mis) begin
            e.kind = 0; e.fault = 1'b1; e.rdata = 32'd0;
        end else begin
            c.we    = we;
            c.addr  = addr & ~32'h3;
            c.wdata = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
            c.be    = we ? (4'((1 << sz) - 1) << addr[1:0]) : 4'b0000;
            cmdq.push_back(c);
            if (tmo) begin
                e.kind = 2; e.cyc = cyc + 1 + TMO; e.fault = 1'b1; e.rdata = 32'd0;
            end else begin
                e.kind = 1; e.fault = 1'b0; e.rdata = 32'd0;
                if (we) begin
                    for (int i = 0; i < sz; i++) ref_bytes[off + i] = wdata[8*i +: 8];
                end else begin
                    v = 32'd0;
                    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_bytes[off + i];
                    if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                    if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                    e.rdata = v;
                end
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb.size() != 0 || !req_ready) && guard < 100) begin @(negedge clk); guard++; end
        if (sb.size() != 0) fail("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [2:0]  f3;
        logic [31:0] a;
        bit          we;
        int          saved;
        logic [2:0]  legal_l [0:4];
        legal_l[0] = LB; legal_l[1] = LH; legal_l[2] = LW; legal_l[3] = LBU; legal_l[4] = LHU;

        for (int i = 0; i < 64; i++) begin
            w = (i == 0) ? 32'h80FF_0000 : $urandom;
            mem_words[i] = w;
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
        end

        #1 rst = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        next_wait = 0;
        issue(1'b0, LB, 32'h103, 32'd0, 1'b0);  wait_idle();
        check("lb_sext", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, LBU, 32'h103, 32'd0, 1'b0); wait_idle();
        check("lbu_zext", last_rdata, 32'h0000_0080);

        next_wait = 2;
        issue(1'b1, SW, 32'h100, 32'hDEAD_BEEF, 1'b0); wait_idle();
        check("sw_fault", {31'd0, last_fault}, 32'd0);
        next_wait = 1;
        issue(1'b1, SH, 32'h102, 32'h0000_ABCD, 1'b0); wait_idle();
        check("sh_fault", {31'd0, last_fault}, 32'd0);
        next_wait = 0;
        issue(1'b0, LW, 32'h100, 32'd0, 1'b0); wait_idle();
        check("lw_readback", last_rdata, 32'hABCD_BEEF);

        issue(1'b0, LH, 32'h101, 32'd0, 1'b0); wait_idle();
        check("lh_mis_fault", {31'd0, last_fault}, 32'd1);
        check("lh_mis_rdata", last_rdata, 32'd0);
        issue(1'b0, 3'b011, 32'h100, 32'd0, 1'b0); wait_idle();
        check("f3_011_fault", {31'd0, last_fault}, 32'd1);
        issue(1'b1, 3'b100, 32'h100, 32'h1234_5678, 1'b0); wait_idle();
        check("store_f3_100_fault", {31'd0, last_fault}, 32'd1);

        // Reset in the middle of an access
        next_wait = 50;
        issue(1'b0, LW, 32'h104, 32'd0, 1'b0);
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        sb.delete(); cmdq.delete(); ackq.delete();
        saved = resp_count;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        next_wait = 0;
        repeat (5) @(negedge clk);
        check("midrst_no_resp", resp_count, saved);

        rand_wait = 1'b1;
        for (int n = 0; n < 300; n++) begin
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 85) f3 = we ? 3'($urandom_range(0, 2)) : legal_l[$urandom_range(0, 4)];
            else f3 = 3'($urandom);
            a = 32'h100 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
            issue(we, f3, a, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();
        rand_wait = 1'b0;

`ifdef LSU_TIMEOUT_EN
        next_wait = 1000;
        issue(1'b0, LW, 32'h108, 32'd0, 1'b1); wait_idle();
        check("tmo_fault", {31'd0, last_fault}, 32'd1);
        check("tmo_rdata", last_rdata, 32'd0);
        check("tmo_mem_req", {31'd0, mem_req}, 32'd0);
        next_wait = 0;
`endif

        check("sb_empty", sb.size(), 32'd0);
        check("cmdq_empty", cmdq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
